dsp_mem_deframer: RTL and testbench

Serial-readout deframer that sits directly downstream of the DSP snapshot memory's serial read port, in the read-clock domain. It hunts for the preamble sync word in the incoming bit stream and deserializes the memory payload into fixed-width words. It then checks the postamble sync word and reports done/error status for software readback.

---
 rtl/dsp_mem_deframer.sv | 181 ++++++++++++++++++
 tb/tb_dsp_mem_deframer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mem_deframer.sv
// Serial-readout deframer for the DSP snapshot memory: hunts the preamble,
// deserializes the payload into words, then checks the postamble.
module dsp_mem_deframer #(
  parameter int FrameLength   = 64,
  parameter int WordWidth     = 16,
  parameter int PayloadLength = 101376,
  parameter int HuntTimeout   = 262144,
  localparam int CntW         = $clog2(PayloadLength / WordWidth + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_bit,
  input  logic                   i_bit_vld,
  input  logic                   i_start,
  input  logic [FrameLength-1:0] i_syncword,
  output logic [WordWidth-1:0]   o_word,
  output logic                   o_word_vld,
  output logic [CntW-1:0]        o_word_cnt,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_sync_err,
  output logic                   o_timeout
);

  localparam int HW = $clog2(HuntTimeout + 1);
  localparam int PW = $clog2(PayloadLength + 1);
  localparam int FW = $clog2(FrameLength + 1);
  localparam int BW = $clog2(WordWidth + 1);

  localparam logic [HW-1:0] HuntLast  = HW'(HuntTimeout - 1);
  localparam logic [HW-1:0] QualMin   = HW'(FrameLength - 1);
  localparam logic [PW-1:0] PayLast   = PW'(PayloadLength - 1);
  localparam logic [FW-1:0] FrameLast = FW'(FrameLength - 1);
  localparam logic [BW-1:0] WordLast  = BW'(WordWidth - 1);

  typedef enum logic [2:0] {IDLE, HUNT, PAYLOAD, POST, DONE} state_e;

  state_e                 state_q, state_d;
  logic [FrameLength-1:0] sync_q, sync_d;
  logic [FrameLength-1:0] shift_q, shift_d;
  logic [HW-1:0]          huntCnt_q, huntCnt_d;
  logic [PW-1:0]          payCnt_q, payCnt_d;
  logic [FW-1:0]          postCnt_q, postCnt_d;
  logic [BW-1:0]          bitCnt_q, bitCnt_d;
  logic [WordWidth-1:0]   wordSh_q, wordSh_d;
  logic [WordWidth-1:0]   word_q, word_d;
  logic                   wordVld_q, wordVld_d;
  logic [CntW-1:0]        wordCnt_q, wordCnt_d;
  logic                   done_q, done_d;
  logic                   syncErr_q, syncErr_d;
  logic                   timeout_q, timeout_d;

  logic [FrameLength-1:0] shiftIn;
  logic [WordWidth-1:0]   wordIn;

  assign shiftIn = {shift_q[FrameLength-2:0], i_bit};
  assign wordIn  = {wordSh_q[WordWidth-2:0], i_bit};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      shift_q   <= '0;
      huntCnt_q <= '0;
      payCnt_q  <= '0;
      postCnt_q <= '0;
      bitCnt_q  <= '0;
      wordSh_q  <= '0;
      word_q    <= '0;
      wordVld_q <= 1'b0;
      wordCnt_q <= '0;
      done_q    <= 1'b0;
      syncErr_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      huntCnt_q <= huntCnt_d;
      payCnt_q  <= payCnt_d;
      postCnt_q <= postCnt_d;
      bitCnt_q  <= bitCnt_d;
      wordSh_q  <= wordSh_d;
      word_q    <= word_d;
      wordVld_q <= wordVld_d;
      wordCnt_q <= wordCnt_d;
      done_q    <= done_d;
      syncErr_q <= syncErr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    shift_d   = shift_q;
    huntCnt_d = huntCnt_q;
    payCnt_d  = payCnt_q;
    postCnt_d = postCnt_q;
    bitCnt_d  = bitCnt_q;
    wordSh_d  = wordSh_q;
    word_d    = word_q;
    wordVld_d = 1'b0;
    wordCnt_d = wordCnt_q;
    done_d    = done_q;
    syncErr_d = syncErr_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE, DONE: begin
        // o_word is deliberately kept so software can still read the last word.
        if (i_start) begin
          state_d   = HUNT;
          sync_d    = i_syncword;
          shift_d   = '0;
          huntCnt_d = '0;
          payCnt_d  = '0;
          postCnt_d = '0;
          bitCnt_d  = '0;
          wordSh_d  = '0;
          wordCnt_d = '0;
          done_d    = 1'b0;
          syncErr_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      HUNT: begin
        if (i_bit_vld) begin
          shift_d   = shiftIn;
          huntCnt_d = huntCnt_q + 1'b1;
          // Match is checked first so it wins over a timeout on the same bit.
          if (huntCnt_q >= QualMin && shiftIn == sync_q) begin
            state_d = PAYLOAD;
          end else if (huntCnt_q == HuntLast) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end
      end
      PAYLOAD: begin
        if (i_bit_vld) begin
          wordSh_d = wordIn;
          payCnt_d = payCnt_q + 1'b1;
          if (bitCnt_q == WordLast) begin
            bitCnt_d  = '0;
            word_d    = wordIn;
            wordVld_d = 1'b1;
            wordCnt_d = wordCnt_q + 1'b1;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
          if (payCnt_q == PayLast) begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (i_bit_vld) begin
          shift_d   = shiftIn;
          postCnt_d = postCnt_q + 1'b1;
          if (postCnt_q == FrameLast) begin
            done_d    = 1'b1;
            syncErr_d = (shiftIn != sync_q);
            state_d   = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_word     = word_q;
  assign o_word_vld = wordVld_q;
  assign o_word_cnt = wordCnt_q;
  assign o_busy     = (state_q == HUNT) || (state_q == PAYLOAD) || (state_q == POST);
  assign o_done     = done_q;
  assign o_sync_err = syncErr_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_dsp_mem_deframer.sv
// Self-checking bench for dsp_mem_deframer: a stream-level model predicts
// every output each cycle, plus literal expectations for each scenario.
module tb_dsp_mem_deframer;

  localparam int FL = 64;
  localparam int WW = 16;
  localparam int PL = 64;
  localparam int HT = 200;
  localparam int NW = PL / WW;
  localparam int CW = $clog2(NW + 1);

  localparam logic [63:0] SyncWord = 64'hA5A5_F00F_1234_8765;
  localparam logic [63:0] Payload  = 64'h0123_4567_89AB_CDEF;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          bitIn = 1'b0;
  logic          bitVld = 1'b0;
  logic          start = 1'b0;
  logic [FL-1:0] syncIn = '0;
  logic [WW-1:0] oWord;
  logic          oWordVld;
  logic [CW-1:0] oWordCnt;
  logic          oBusy;
  logic          oDone;
  logic          oSyncErr;
  logic          oTimeout;

  dsp_mem_deframer #(
    .FrameLength(FL),
    .WordWidth(WW),
    .PayloadLength(PL),
    .HuntTimeout(HT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_bit(bitIn),
    .i_bit_vld(bitVld),
    .i_start(start),
    .i_syncword(syncIn),
    .o_word(oWord),
    .o_word_vld(oWordVld),
    .o_word_cnt(oWordCnt),
    .o_busy(oBusy),
    .o_done(oDone),
    .o_sync_err(oSyncErr),
    .o_timeout(oTimeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the stream of the current capture and what it implies.
  bit            streamQ[$];
  logic [FL-1:0] syncRef;
  int            modelP0;
  bit            modelTimeout;
  logic [WW-1:0] modelWords[NW];
  bit            modelErr;
  bit            active = 1'b0;
  int            qIdx = 0;
  logic [WW-1:0] heldWord = '0;
  int            firstVldIdx = -1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Finds the preamble end, words and postamble verdict straight from the bit stream.
  function automatic void computeModel();
    logic [FL-1:0] w;
    modelTimeout = 1'b1;
    modelP0 = -1;
    modelErr = 1'b0;
    for (int i = FL - 1; i < streamQ.size() && i < HT; i++) begin
      for (int j = 0; j < FL; j++) w[FL-1-j] = streamQ[i-FL+1+j];
      if (w == syncRef) begin
        modelP0 = i + 1;
        modelTimeout = 1'b0;
        break;
      end
    end
    if (!modelTimeout) begin
      for (int k = 0; k < NW; k++)
        for (int b = 0; b < WW; b++)
          modelWords[k][WW-1-b] = streamQ[modelP0 + k*WW + b];
      for (int j = 0; j < FL; j++) w[FL-1-j] = streamQ[modelP0 + PL + j];
      modelErr = (w != syncRef);
    end
  endfunction

  function automatic bit modelDone(input int n);
    if (modelTimeout) return n >= HT;
    return n >= modelP0 + PL + FL;
  endfunction

  task automatic checkCycle(input bit stepped);
    int  expCnt;
    bit  expVld;
    bit  expDone;
    if (!active) begin
      checkOutput("idle vld", oWordVld, 0);
      checkOutput("idle word", oWord, heldWord);
      checkOutput("idle cnt", oWordCnt, 0);
      checkOutput("idle busy", oBusy, 0);
      checkOutput("idle done", oDone, 0);
      checkOutput("idle err", oSyncErr, 0);
      checkOutput("idle timeout", oTimeout, 0);
      return;
    end
    expCnt = 0;
    expVld = 1'b0;
    if (!modelTimeout) begin
      for (int k = 0; k < NW; k++) begin
        if (qIdx >= modelP0 + WW*(k+1)) expCnt++;
        if (stepped && qIdx == modelP0 + WW*(k+1)) begin
          expVld = 1'b1;
          heldWord = modelWords[k];
        end
      end
    end
    expDone = modelDone(qIdx);
    checkOutput("word vld", oWordVld, expVld);
    checkOutput("word", oWord, heldWord);
    checkOutput("word cnt", oWordCnt, expCnt);
    checkOutput("busy", oBusy, !expDone);
    checkOutput("done", oDone, expDone);
    checkOutput("sync err", oSyncErr, expDone && !modelTimeout && modelErr);
    checkOutput("timeout", oTimeout, expDone && modelTimeout);
    if (oWordVld && firstVldIdx < 0) firstVldIdx = qIdx;
  endtask

  // Single compare process: tracks qualified bits and checks every cycle.
  always @(posedge clk) begin
    bit stepped;
    stepped = 1'b0;
    if (rstN && start && (!active || modelDone(qIdx))) begin
      computeModel();
      active = 1'b1;
      qIdx = 0;
      firstVldIdx = -1;
    end else if (rstN && active && bitVld) begin
      qIdx++;
      stepped = 1'b1;
    end
    #1;
    checkCycle(stepped);
  end

  task automatic buildFrame(input int nPre, input logic [63:0] preBits, input bit corrupt);
    logic [63:0] post;
    streamQ.delete();
    post = SyncWord ^ {63'd0, corrupt};
    for (int j = 0; j < nPre; j++) streamQ.push_back(preBits[nPre-1-j]);
    for (int j = 0; j < FL; j++) streamQ.push_back(SyncWord[FL-1-j]);
    for (int j = 0; j < PL; j++) streamQ.push_back(Payload[PL-1-j]);
    for (int j = 0; j < FL; j++) streamQ.push_back(post[FL-1-j]);
    for (int j = 0; j < 8; j++) streamQ.push_back(1'b0);
  endtask

  task automatic startCapture();
    @(negedge clk);
    syncRef = SyncWord;
    syncIn = SyncWord;
    start = 1'b1;
    bitVld = 1'b0;
    @(negedge clk);
    start = 1'b0;
    syncIn = ~SyncWord;
  endtask

  task automatic applyStimulus(input bit gapped, input int maxBits, input int startAt);
    int i = 0;
    int cycles = 0;
    bit pulsed = 1'b0;
    while (i < streamQ.size() && i < maxBits) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (cycles > 10000) begin
        checks++;
        errors++;
        $display("[TB] FAIL stimulus budget: actual=%0d bits required=%0d bits", i, maxBits);
        break;
      end
      bitVld = gapped ? ($urandom_range(0, 1) == 1) : 1'b1;
      bitIn = bitVld ? streamQ[i] : 1'($urandom_range(0, 1));
      if (bitVld && i == startAt && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (bitVld) i++;
    end
    @(negedge clk);
    start = 1'b0;
    bitVld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkFinal(input string tag, input int expCnt, input logic [WW-1:0] expWord, input bit expErr);
    checkOutput({tag, " cnt"}, oWordCnt, expCnt);
    checkOutput({tag, " last word"}, oWord, expWord);
    checkOutput({tag, " done"}, oDone, 1);
    checkOutput({tag, " sync err"}, oSyncErr, expErr);
    checkOutput({tag, " busy"}, oBusy, 0);
  endtask

  initial begin
    logic [63:0] preBits;
    preBits = 64'h0A_5C3D_9E1F;
    repeat (3) @(negedge clk);
    checkOutput("reset word", oWord, 0);
    checkOutput("reset done", oDone, 0);
    checkOutput("reset busy", oBusy, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] clean frame");
    buildFrame(0, '0, 1'b0);
    startCapture();
    checkOutput("busy after start", oBusy, 1);
    applyStimulus(1'b0, 1000, -1);
    checkOutput("model p0 clean", modelP0, 64);
    checkOutput("model word0", modelWords[0], 16'h0123);
    checkOutput("model word1", modelWords[1], 16'h4567);
    checkOutput("model word2", modelWords[2], 16'h89AB);
    checkOutput("model word3", modelWords[3], 16'hCDEF);
    checkOutput("clean first vld", firstVldIdx, 80);
    checkFinal("clean", 4, 16'hCDEF, 1'b0);

    $display("[TB] misaligned preamble");
    buildFrame(37, preBits, 1'b0);
    startCapture();
    applyStimulus(1'b0, 1000, -1);
    checkOutput("model p0 misaligned", modelP0, 101);
    checkOutput("misaligned first vld", firstVldIdx, 117);
    checkFinal("misaligned", 4, 16'hCDEF, 1'b0);

    $display("[TB] corrupt postamble");
    buildFrame(0, '0, 1'b1);
    startCapture();
    applyStimulus(1'b0, 1000, -1);
    checkOutput("model err corrupt", modelErr, 1);
    checkFinal("corrupt", 4, 16'hCDEF, 1'b1);

    $display("[TB] hunt timeout");
    streamQ.delete();
    for (int j = 0; j < 250; j++) streamQ.push_back(1'b0);
    startCapture();
    applyStimulus(1'b0, 1000, -1);
    checkOutput("timeout flag", oTimeout, 1);
    checkOutput("timeout done", oDone, 1);
    checkOutput("timeout cnt", oWordCnt, 0);
    checkOutput("timeout no vld", firstVldIdx < 0, 1);

    $display("[TB] gapped valid with ignored start");
    buildFrame(0, '0, 1'b0);
    startCapture();
    applyStimulus(1'b1, 1000, 84);
    checkFinal("gapped", 4, 16'hCDEF, 1'b0);

    $display("[TB] reset mid-payload");
    buildFrame(0, '0, 1'b0);
    startCapture();
    applyStimulus(1'b0, 64 + 32 + 5, -1);
    checkOutput("pre-reset cnt", oWordCnt, 2);
    @(negedge clk);
    rstN = 1'b0;
    active = 1'b0;
    heldWord = '0;
    #1;
    checkOutput("reset mid word", oWord, 0);
    checkOutput("reset mid cnt", oWordCnt, 0);
    checkOutput("reset mid busy", oBusy, 0);
    checkOutput("reset mid vld", oWordVld, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    startCapture();
    applyStimulus(1'b0, 1000, -1);
    checkFinal("after reset", 4, 16'hCDEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
